// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size/state encodings and helpers for the load/store unit
package lsu_pkg;

  localparam int NWORDS_DEFAULT = 1024;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_WRITE  = 2'b10,
    S_DONE   = 2'b11
  } lsu_state_e;

  // Reserved size behaves as a full word whenever it is not rejected.
  function automatic logic lsu_is_word(input logic [1:0] size);
    return size[1];
  endfunction

  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (lsu_size_e'(size))
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      SZ_RSVD: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and data-memory signals of the load/store unit
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sext;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              ready;
  logic              valid;
  logic [31:0]       rdata;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we_n;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output req, we, size, sext, addr, wdata, mem_rdata,
    input  ready, valid, rdata, err, mem_addr, mem_we_n, mem_wdata
  );

  modport slave (
    input  req, we, size, sext, addr, wdata, mem_rdata,
    output ready, valid, rdata, err, mem_addr, mem_we_n, mem_wdata
  );
endinterface

// File: rtl/lsu_lane_merge.sv
// rtl/lsu_lane_merge.sv - little-endian lane extraction/extension for loads and lane merge for stores
module lsu_lane_merge
  import lsu_pkg::*;
(
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [1:0]  offset,
  output logic [31:0] ldata,
  output logic [31:0] merged
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rword[{offset, 3'b000} +: 8];
    lane_h = offset[1] ? rword[31:16] : rword[15:0];
    ldata  = rword;
    merged = wdata;
    case (lsu_size_e'(size))
      SZ_BYTE: begin
        ldata  = {{24{sext & lane_b[7]}}, lane_b};
        merged = rword;
        merged[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        ldata  = {{16{sext & lane_h[15]}}, lane_h};
        merged = offset[1] ? {wdata[15:0], rword[15:0]} : {rword[31:16], wdata[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-port load/store FSM; LSU_ALIGN_CHECK_EN enables misalignment rejection
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int NWORDS = NWORDS_DEFAULT,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.slave  bus
);

  if (NWORDS < 1) begin : g_bad_nwords
    $error("load_store_unit: NWORDS must be at least 1");
  end

  lsu_state_e  state;
  logic        we_q;
  logic        sext_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [31:0] ld_data;
  logic [31:0] st_merged;
  logic        bad_req;
  logic        bad_q;

  lsu_lane_merge u_lane_merge (
    .rword  (bus.mem_rdata),
    .wdata  (wdata_q),
    .size   (size_q),
    .sext   (sext_q),
    .offset (off_q),
    .ldata  (ld_data),
    .merged (st_merged)
  );

`ifdef LSU_ALIGN_CHECK_EN
  logic err_q;

  assign bad_req = lsu_misaligned(bus.size, bus.addr[1:0]);
  assign bad_q   = lsu_misaligned(size_q, off_q);
  assign bus.err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state == S_IDLE && bus.req) begin
      err_q <= 1'b0;
    end else if (state == S_ACCESS && bad_q) begin
      err_q <= 1'b1;
    end
  end
`else
  assign bad_req = 1'b0;
  assign bad_q   = 1'b0;
  assign bus.err = 1'b0;
`endif

  assign bus.ready = (state == S_IDLE);
  assign bus.valid = rd_valid;
  assign bus.rdata = rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      rd_valid      <= 1'b0;
      rd_data       <= 32'h0;
      bus.mem_we_n  <= 1'b1;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= 32'h0;
      we_q          <= 1'b0;
      sext_q        <= 1'b0;
      size_q        <= SZ_BYTE;
      off_q         <= 2'b00;
      wdata_q       <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          rd_valid <= 1'b0;
          if (bus.req) begin
            we_q         <= bus.we;
            sext_q       <= bus.sext;
            size_q       <= bus.size;
            off_q        <= bus.addr[1:0];
            wdata_q      <= bus.wdata;
            bus.mem_addr <= {2'b00, bus.addr[ADDR_W-1:2]};
            state        <= S_ACCESS;
            // Word stores go straight to memory so the strobe covers all of ACCESS.
            if (bus.we && lsu_is_word(bus.size) && !bad_req) begin
              bus.mem_we_n  <= 1'b0;
              bus.mem_wdata <= bus.wdata;
            end
          end
        end
        S_ACCESS: begin
          if (bad_q || !we_q || lsu_is_word(size_q)) begin
            if (!bad_q && !we_q) begin
              rd_data <= ld_data;
            end
            bus.mem_we_n <= 1'b1;
            rd_valid     <= 1'b1;
            state        <= S_DONE;
          end else begin
            // Sub-word store: read-modify-write through the merged word.
            bus.mem_wdata <= st_merged;
            bus.mem_we_n  <= 1'b0;
            state         <= S_WRITE;
          end
        end
        S_WRITE: begin
          bus.mem_we_n <= 1'b1;
          rd_valid     <= 1'b1;
          state        <= S_DONE;
        end
        S_DONE: begin
          rd_valid <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed and random checks of load_store_unit against a word-array model
module tb_load_store_unit;

  logic clk;
  logic rst_n;

  load_store_unit_if #(.ADDR_W(32)) bus ();

  load_store_unit #(.NWORDS(1024), .ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  logic [31:0] refmem [0:1023];
  logic        poke_en;
  logic [9:0]  poke_idx;
  logic [31:0] poke_data;
  int          wr_total = 0;
  logic [31:0] last_rdata;
  int          n_checks = 0;
  int          n_fail = 0;

  assign bus.mem_rdata = mem[bus.mem_addr[9:0]];

  always @(negedge clk) begin
    if (poke_en) begin
      mem[poke_idx] <= poke_data;
    end else if (!bus.mem_we_n) begin
      mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
      wr_total <= wr_total + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] data);
    poke_en   = 1'b1;
    poke_idx  = idx[9:0];
    poke_data = data;
    refmem[idx] = data;
    @(negedge clk);
    #1;
    poke_en = 1'b0;
  endtask

  task automatic access(input bit w, input logic [1:0] sz, input bit sx,
                        input logic [31:0] a, input logic [31:0] wd, input bit b2b);
    int          idx;
    int          nbytes;
    int          sh;
    int          lat;
    int          n;
    int          wr0;
    bit          bad;
    logic [31:0] mask;
    logic [31:0] val;
    idx = int'(a[11:2]);
    bad = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    bad = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || (sz == 2'd3);
`endif
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    sh     = (sz == 2'd0) ? 8 * int'(a[1:0]) : (sz == 2'd1) ? (a[1] ? 16 : 0) : 0;
    mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    lat    = (bad || !w || nbytes == 4) ? 2 : 3;
    if (b2b) lat++;
    if (!bad) begin
      if (!w) begin
        val = (refmem[idx] >> sh) & mask;
        if (sx && nbytes < 4 && val[8 * nbytes - 1]) val = val | ~mask;
        last_rdata = val;
      end else begin
        refmem[idx] = (refmem[idx] & ~(mask << sh)) | ((wd & mask) << sh);
      end
    end

    if (!b2b) begin
      n = 0;
      while (!bus.ready && n < 10) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("ready_before_req", {31'b0, bus.ready}, 32'd1);
    end
    wr0       = wr_total;
    bus.req   = 1'b1;
    bus.we    = w;
    bus.size  = sz;
    bus.sext  = sx;
    bus.addr  = a;
    bus.wdata = wd;
    repeat (b2b ? 2 : 1) @(posedge clk);
    #1;
    bus.req = 1'b0;
    n = b2b ? 2 : 1;
    while (!bus.valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("valid_seen", {31'b0, bus.valid}, 32'd1);
    chk("latency", n, lat);
    chk("ready_in_done", {31'b0, bus.ready}, 32'd0);
    chk("mem_addr", bus.mem_addr, idx);
    chk("rdata", bus.rdata, last_rdata);
    chk("err", {31'b0, bus.err}, {31'b0, bad});
    chk("write_count", wr_total - wr0, (w && !bad) ? 1 : 0);
    chk("mem_word", mem[idx], refmem[idx]);
  endtask

  initial begin
    poke_en   = 1'b0;
    poke_idx  = '0;
    poke_data = '0;
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.size  = 2'b00;
    bus.sext  = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    last_rdata = 32'h0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", {31'b0, bus.ready}, 32'd1);
    chk("rst_valid", {31'b0, bus.valid}, 32'd0);
    chk("rst_err", {31'b0, bus.err}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_mem_we_n", {31'b0, bus.mem_we_n}, 32'd1);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    for (int i = 0; i < 32; i++) poke(i, $urandom);
    @(negedge clk);
    #1 rst_n = 1'b1;

    access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("word_load_rdata", bus.rdata, 32'hDEADBEEF);
    chk("word_load_mem_addr", bus.mem_addr, 32'd4);

    access(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 1'b0);
    access(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA, 1'b0);
    chk("byte_store_word", mem[4], 32'h1122AA44);

    access(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF0000, 1'b0);
    access(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b0);
    chk("byte_load_sext", bus.rdata, 32'hFFFFFF80);
    access(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b1);
    chk("byte_load_zext", bus.rdata, 32'h00000080);

`ifdef LSU_ALIGN_CHECK_EN
    access(1'b1, 2'd2, 1'b0, 32'h12, 32'h12345678, 1'b0);
    chk("misaligned_err", {31'b0, bus.err}, 32'd1);
    chk("misaligned_mem", mem[4], 32'h80FF0000);
`endif

    // Reset while the merged word is about to be written.
    access(1'b1, 2'd2, 1'b0, 32'h40, 32'h11223344, 1'b0);
    @(posedge clk);
    #1;
    bus.req  = 1'b1;
    bus.we   = 1'b1;
    bus.size = 2'd0;
    bus.addr = 32'h41;
    bus.wdata = 32'h55;
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(posedge clk);
    #1;
    chk("write_pending", {31'b0, bus.mem_we_n}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", {31'b0, bus.ready}, 32'd1);
    chk("abort_mem_we_n", {31'b0, bus.mem_we_n}, 32'd1);
    chk("abort_valid", {31'b0, bus.valid}, 32'd0);
    @(negedge clk);
    #1;
    chk("abort_mem_word", mem[16], 32'h11223344);
    last_rdata = 32'h0;
    rst_n = 1'b1;

    for (int k = 0; k < 60; k++) begin
      access($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
             32'($urandom_range(0, 127)), $urandom, (k > 0) && ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter NWORDS, default 1024, SHALL give the data-memory depth in 32-bit words.
REQ-002 Parameter ADDR_W, default 32, SHALL give the byte-address and memory-address width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req  input  1  SHALL request an access; sampled only when ready=1.
REQ-006 we  input  1  SHALL select store (1) or load (0).
REQ-007 size  input  2  SHALL encode the access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-008 sext  input  1  SHALL select sign-extension (1) or zero-extension (0) for sub-word loads.
REQ-009 addr  input  ADDR_W  SHALL carry the byte address.
REQ-010 wdata  input  32  SHALL carry store data, right-aligned for sub-word stores.
REQ-011 ready  output  1  SHALL be 1 exactly when the unit is in IDLE.
REQ-012 valid  output  1  SHALL pulse for one cycle on access completion.
REQ-013 rdata  output  32  SHALL hold load result; valid while valid=1.
REQ-014 err  output  1  SHALL flag a rejected access, qualified by valid.
REQ-015 mem_addr  output  ADDR_W  SHALL drive the memory word index, {2'b00, addr[ADDR_W-1:2]}.
REQ-016 mem_we_n  output  1  SHALL be the active-low memory write enable; memory writes on the negedge while low.
REQ-017 mem_wdata  output  32  SHALL drive the full word to be written.
REQ-018 mem_rdata  input  32  SHALL be the memory's combinational read data for mem_addr.

Function
REQ-019 FSM SHALL have states IDLE, ACCESS, WRITE, DONE.
REQ-020 IDLE: on posedge with req=1, SHALL latch we, size, sext, addr, wdata and go to ACCESS; req=0 stays IDLE.
REQ-021 ACCESS load: SHALL extract selected lane(s) from mem_rdata, extend per sext, register into rdata, go DONE.
REQ-022 ACCESS word store: SHALL drive mem_we_n=0, mem_wdata=latched wdata for the whole cycle, go DONE.
REQ-023 ACCESS sub-word store: SHALL hold mem_we_n=1, register mem_rdata with the new lane(s) merged in, go WRITE.
REQ-024 WRITE: SHALL drive mem_we_n=0 with the merged word, go DONE.
REQ-025 DONE: SHALL assert valid for one cycle, return to IDLE; ready=0 in DONE.
REQ-026 Latency req-sample to valid SHALL be 2 cycles for loads and word stores, 3 cycles for byte/half stores.
REQ-027 Lanes SHALL be little-endian: byte k = bits 8k+7:8k selected by addr[1:0]; half selected by addr[1].
REQ-028 mem_we_n SHALL be 1 in IDLE, DONE, and in ACCESS for loads and sub-word stores.
REQ-029 rdata SHALL hold its last value after stores and between accesses; err SHALL clear on every new accepted request.
REQ-030 req held high in DONE SHALL NOT be accepted until the following IDLE cycle.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, ready=1, valid=0, err=0, rdata=0, mem_we_n=1, mem_addr=0, mem_wdata=0.
REQ-032 Reset in ACCESS or WRITE SHALL abort the access; a write is suppressed if rst_n falls before that cycle's negedge.

Configuration
REQ-033 With LSU_ALIGN_CHECK_EN defined, misaligned half (addr[0]=1), misaligned word (addr[1:0]!=0) or size=11 SHALL skip memory (mem_we_n stays 1), go ACCESS->DONE with err=1, rdata unchanged.
REQ-034 Without LSU_ALIGN_CHECK_EN, err SHALL be tied 0, misaligned low address bits ignored (half uses addr[1], word ignores addr[1:0]), size=11 treated as word.

Structure
REQ-035 Package lsu_pkg SHALL hold size encodings, FSM state encodings and the NWORDS default.
REQ-036 Combinational sub-module lsu_lane_merge SHALL implement lane extraction/extension and store merge, shared by ACCESS and WRITE.

Verification
REQ-037 Reset mid-WRITE: assert rst_n=0 before negedge -> memory word unchanged, ready=1 immediately.
REQ-038 Word store addr=0x10, wdata=0xDEADBEEF then word load addr=0x10 -> mem_addr=4, rdata=0xDEADBEEF, valid 2 cycles after each req.
REQ-039 Byte store 0xAA to addr=0x11 over word 0x11223344 -> word becomes 0x1122AA44, valid 3 cycles after req.
REQ-040 Byte load addr=0x13 from 0x80FF0000, sext=1 -> rdata=0xFFFFFF80; sext=0 -> 0x00000080.
REQ-041 With LSU_ALIGN_CHECK_EN, word store addr=0x12 -> err=1 with valid, mem_we_n never 0, memory unchanged.
